// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dsm_pkg
//  Brief   : Shared delta-sigma constants, warm-up state type, sizing helpers.
//  Revision: 1.0
// ============================================================================
package dsm_pkg;

    localparam int BW_DEF       = 16;
    localparam int DEC_LOG2_DEF = 6;
    localparam int ORDER        = 3;
    localparam int ACC_W        = ORDER * DEC_LOG2_DEF + 2;
    localparam int SHIFT        = ORDER * DEC_LOG2_DEF + 1 - BW_DEF;
    localparam int PCM_MAX      = (1 << (BW_DEF - 1)) - 1;
    localparam int PCM_MIN      = -(1 << (BW_DEF - 1));

    typedef enum logic [1:0] {
        WARM_0    = 2'd0,
        WARM_1    = 2'd1,
        WARM_DONE = 2'd2
    } warm_e;

    function automatic int acc_width(input int dec_log2);
        return ORDER * dec_log2 + 2;
    endfunction

    function automatic int shift_amt(input int bw, input int dec_log2);
        return ORDER * dec_log2 + 1 - bw;
    endfunction

    function automatic int pcm_max(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    function automatic int pcm_min(input int bw);
        return -(1 << (bw - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsm_comb_stage.sv
`default_nettype none
// ============================================================================
//  Module  : dsm_comb_stage
//  Brief   : One CIC differentiator (delay 1): dout = din - previous din.
//  Revision: 1.0
// ============================================================================
module dsm_comb_stage #(
    parameter int W = 20
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] dout_o
);

    logic signed [W-1:0] dly_q;
    logic signed [W-1:0] dly_d;

    always_comb begin
        dly_d = dly_q;
        if (en_i) begin
            dly_d = din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign dout_o = din_i - dly_q;

endmodule
`default_nettype wire

// File: rtl/dsm_decimator.sv
`default_nettype none
// ============================================================================
//  Module  : dsm_decimator
//  Brief   : 3rd-order CIC decimator turning a 1-bit delta-sigma stream into
//            saturated signed PCM with a valid/ready output register.
//  Revision: 1.0
// ============================================================================
module dsm_decimator
    import dsm_pkg::*;
#(
    parameter int BW       = BW_DEF,
    parameter int DEC_LOG2 = DEC_LOG2_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 bit_i,
    output logic signed [BW-1:0] pcm_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o
);

    localparam int AW = acc_width(DEC_LOG2);
    localparam int SH = shift_amt(BW, DEC_LOG2);

    localparam logic signed [AW-1:0]   STEP_UP  = AW'(1);
    localparam logic signed [AW-1:0]   STEP_DN  = '1;
    localparam logic [DEC_LOG2-1:0]    CNT_ONE  = DEC_LOG2'(1);
    localparam logic [DEC_LOG2-1:0]    CNT_LAST = '1;
    localparam logic signed [AW-1:0]   SAT_HI   = AW'(pcm_max(BW));
    localparam logic signed [AW-1:0]   SAT_LO   = AW'(pcm_min(BW));

    logic signed [AW-1:0] integ0_q, integ0_d;
    logic signed [AW-1:0] integ1_q, integ1_d;
    logic signed [AW-1:0] integ2_q, integ2_d;
    logic [DEC_LOG2-1:0]  cnt_q, cnt_d;
    logic                 strobe_q, strobe_d;
    logic signed [AW-1:0] comb_res_q, comb_res_d;
    logic                 comb_vld_q, comb_vld_d;
    warm_e                warm_q, warm_d;
    logic signed [BW-1:0] pcm_q, pcm_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic signed [AW-1:0] w_step;
    logic signed [AW-1:0] w_comb0;
    logic signed [AW-1:0] w_comb1;
    logic signed [AW-1:0] w_comb2;
    logic signed [AW-1:0] w_shifted;
    logic                 w_load;

    assign w_step = bit_i ? STEP_UP : STEP_DN;

    // Integrators chain through the freshly updated value of the previous stage.
    always_comb begin
        integ0_d = integ0_q;
        integ1_d = integ1_q;
        integ2_d = integ2_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (en_i) begin
            integ0_d = integ0_q + w_step;
            integ1_d = integ1_q + integ0_d;
            integ2_d = integ2_q + integ1_d;
            cnt_d    = cnt_q + CNT_ONE;
            strobe_d = (cnt_q == CNT_LAST);
        end
    end

    dsm_comb_stage #(.W(AW)) u_comb0 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (strobe_q),
        .din_i  (integ2_q),
        .dout_o (w_comb0)
    );

    dsm_comb_stage #(.W(AW)) u_comb1 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (strobe_q),
        .din_i  (w_comb0),
        .dout_o (w_comb1)
    );

    dsm_comb_stage #(.W(AW)) u_comb2 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (strobe_q),
        .din_i  (w_comb1),
        .dout_o (w_comb2)
    );

    always_comb begin
        comb_res_d = comb_res_q;
        comb_vld_d = strobe_q;
        if (strobe_q) begin
            comb_res_d = w_comb2;
        end
    end

    // Warm-up: the first two comb results carry the filter start-up transient.
    always_comb begin
        warm_d = warm_q;
        w_load = 1'b0;
        if (comb_vld_q) begin
            case (warm_q)
                WARM_0:    warm_d = WARM_1;
                WARM_1:    warm_d = WARM_DONE;
                WARM_DONE: w_load = 1'b1;
                default:   warm_d = WARM_0;
            endcase
        end
    end

    assign w_shifted = comb_res_q >>> SH;

    always_comb begin
        pcm_d     = pcm_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (w_load) begin
            if (w_shifted > SAT_HI) begin
                pcm_d = BW'(SAT_HI);
            end else if (w_shifted < SAT_LO) begin
                pcm_d = BW'(SAT_LO);
            end else begin
                pcm_d = BW'(w_shifted);
            end
            valid_d = 1'b1;
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            integ0_q   <= '0;
            integ1_q   <= '0;
            integ2_q   <= '0;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            comb_res_q <= '0;
            comb_vld_q <= 1'b0;
            warm_q     <= WARM_0;
            pcm_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            integ0_q   <= integ0_d;
            integ1_q   <= integ1_d;
            integ2_q   <= integ2_d;
            cnt_q      <= cnt_d;
            strobe_q   <= strobe_d;
            comb_res_q <= comb_res_d;
            comb_vld_q <= comb_vld_d;
            warm_q     <= warm_d;
            pcm_q      <= pcm_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pcm_o     = pcm_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule
`default_nettype wire
